// File: rtl/softmax_stream_arbiter.sv
// Round-robin, vector-granular sharing of one softmax datapath among NUM_REQ streams.
// A tag FIFO records the grant order so result vectors are steered back to their owners.
module softmax_stream_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IN_NUM     = 1,
   parameter int OUT_NUM    = 1,
   parameter int IN_DEPTH   = 10,
   parameter int OUT_DEPTH  = 10,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ*IN_NUM*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic [IN_NUM*DATA_WIDTH-1:0]         sm_in_data,
   output logic                                 sm_in_valid,
   input  logic                                 sm_in_ready,
   input  logic [OUT_NUM*DATA_WIDTH-1:0]        sm_out_data,
   input  logic                                 sm_out_valid,
   output logic                                 sm_out_ready,
   output logic [OUT_NUM*DATA_WIDTH-1:0]        rsp_data,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   input  logic [NUM_REQ-1:0]                   rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]           grant_id,
   output logic                                 busy,
   output logic                                 protocol_err
);
   localparam int GW  = $clog2(NUM_REQ);
   localparam int IW  = IN_NUM*DATA_WIDTH;
   localparam int ICW = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
   localparam int OCW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW  = $clog2(TAG_DEPTH+1);
   localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_DEPTH-1);
   localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_DEPTH-1);
   localparam logic [PW-1:0]  PTR_LAST = PW'(TAG_DEPTH-1);
   localparam logic [CW-1:0]  TAG_FULL = CW'(TAG_DEPTH);

   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_nxt;

   logic [GW-1:0]  last_grant, win, idx;
   logic           win_vld;
   logic [ICW-1:0] in_cnt;
   logic [OCW-1:0] out_cnt;
   logic [GW-1:0]  tag_mem [TAG_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  tag_cnt;
   logic [GW-1:0]  head;
   logic           tag_ne, in_hs, out_hs, push, pop;

   // first valid requester after last_grant, wrapping
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = GW'((int'(last_grant) + i) % NUM_REQ);
         if (!win_vld && req_valid[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   // full check uses the registered count, so a same-cycle pop never enables a grant
   assign push = (state == IDLE) && win_vld && (tag_cnt < TAG_FULL);

   always_comb begin
      state_nxt   = state;
      sm_in_valid = 1'b0;
      req_ready   = '0;
      sm_in_data  = req_data[grant_id*IW +: IW];
      case (state)
         IDLE:    if (push) state_nxt = STREAM;
         STREAM: begin
            sm_in_valid         = req_valid[grant_id] & rst;
            req_ready[grant_id] = sm_in_ready & rst;
            if (req_valid[grant_id] && sm_in_ready && in_cnt == IN_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_hs  = sm_in_valid & sm_in_ready;
   assign tag_ne = (tag_cnt != '0);
   assign head   = tag_mem[rd_ptr];

   always_comb begin
      rsp_valid    = '0;
      sm_out_ready = 1'b0;
      if (rst && tag_ne) begin
         rsp_valid[head] = sm_out_valid;
         sm_out_ready    = rsp_ready[head];
      end
   end

   assign rsp_data = sm_out_data;
   assign out_hs   = sm_out_valid & sm_out_ready;
   assign pop      = out_hs && (out_cnt == OUT_LAST);
   assign busy     = (state == STREAM) || tag_ne;

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= win;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= GW'(NUM_REQ-1);
         grant_id     <= '0;
         in_cnt       <= '0;
         out_cnt      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         tag_cnt      <= '0;
         protocol_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) begin
            grant_id <= win;
            wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (in_hs) begin
            if (in_cnt == IN_LAST) begin
               in_cnt     <= '0;
               last_grant <= grant_id;
            end else begin
               in_cnt <= in_cnt + 1'b1;
            end
         end
         if (out_hs) out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
         if (!tag_ne && sm_out_valid) protocol_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_softmax_stream_arbiter.sv
// Bench for softmax_stream_arbiter: requester BFMs, a toy datapath (out = in ^ 8'h5A)
// and an in-order response scoreboard filled as requester beats are accepted.
module tb_softmax_stream_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_valid = '0, req_ready;
   logic [7:0]  sm_in_data;
   logic        sm_in_valid, sm_in_ready = 1'b1;
   logic [7:0]  sm_out_data = '0;
   logic        sm_out_valid = 1'b0, sm_out_ready;
   logic [7:0]  rsp_data;
   logic [3:0]  rsp_valid, rsp_ready = '1;
   logic [1:0]  grant_id;
   logic        busy, protocol_err;

   softmax_stream_arbiter dut (
      .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
      .sm_in_data(sm_in_data), .sm_in_valid(sm_in_valid), .sm_in_ready(sm_in_ready),
      .sm_out_data(sm_out_data), .sm_out_valid(sm_out_valid), .sm_out_ready(sm_out_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int want[4] = '{default:0};
   int sent[4] = '{default:0};
   int beat[4] = '{default:0};
   int acc[4]  = '{default:0};
   int rsp_per[4] = '{default:0};
   int cyc, vin, vout, vec_start_cnt, vec_out_cnt, first_in_cyc, last_in_cyc, last_pop_cyc, cur_owner;
   bit gap_chk = 0, out_hold = 0, force_ov = 0;
   logic [9:0] exp_q[$];
   logic [7:0] dp_in[$], dp_q[$];
   int exp_grant[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk); #3;
   endtask

   function automatic bit all_sent();
      for (int r = 0; r < 4; r++) if (sent[r] != want[r]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string tag, input int lim);
      int n = 0;
      while ((busy || !all_sent()) && n < lim) begin step(); n++; end
      chk(tag, 32'(n < lim), 1);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   // monitors at negedge, drives at posedge+1
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            for (int r = 0; r < 4; r++) begin beat[r] = 0; sent[r] = want[r]; end
            exp_q.delete(); dp_in.delete(); dp_q.delete(); vin = 0; vout = 0;
         end else begin
            for (int r = 0; r < 4; r++) if (req_valid[r] && req_ready[r]) begin
               exp_q.push_back({2'(r), 8'(r*16 + beat[r]) ^ 8'h5A});
               acc[r]++; beat[r]++;
               if (beat[r] == 10) begin beat[r] = 0; sent[r]++; end
            end
            if (sm_in_valid && sm_in_ready) begin
               if (vin == 0) begin
                  chk("grant_q", 32'(exp_grant.size() != 0), 1);
                  if (exp_grant.size() != 0) chk("grant_order", grant_id, exp_grant.pop_front());
                  if (gap_chk) chk("idle_gap", cyc - last_in_cyc, 2);
                  cur_owner = grant_id; first_in_cyc = cyc; vec_start_cnt++;
               end
               chk("in_owner", req_ready, 32'(1) << cur_owner);
               chk("in_data", sm_in_data, 8'(cur_owner*16 + vin));
               dp_in.push_back(sm_in_data); vin++; last_in_cyc = cyc;
               if (vin == 10) begin
                  foreach (dp_in[k]) dp_q.push_back(dp_in[k] ^ 8'h5A);
                  dp_in.delete(); vin = 0;
               end
            end
            if (sm_out_valid && sm_out_ready) begin
               if (dp_q.size() != 0) void'(dp_q.pop_front());
               chk("rsp_q", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_valid", rsp_valid, 32'(1) << e[9:8]);
                  chk("rsp_data", rsp_data, e[7:0]);
                  rsp_per[e[9:8]]++;
               end
               vout++;
               if (vout == 10) begin vout = 0; vec_out_cnt++; last_pop_cyc = cyc; end
            end
         end
         @(posedge clk); #1;
         for (int r = 0; r < 4; r++) begin
            req_valid[r] = (want[r] > sent[r]);
            req_data[r*8 +: 8] = 8'(r*16 + beat[r]);
         end
         sm_out_valid = force_ov || (dp_q.size() != 0 && !out_hold);
         sm_out_data  = (dp_q.size() != 0) ? dp_q[0] : 8'h00;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n, base, pop_c;
      repeat (3) step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_sm_in_valid", sm_in_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_sm_out_ready", sm_out_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_perr", protocol_err, 0);
      rst = 1'b1;
      step();
      chk("post_rst_req_ready", req_ready, 0);
      chk("post_rst_sm_in_valid", sm_in_valid, 0);
      chk("post_rst_sm_out_ready", sm_out_ready, 0);

      // single requester
      exp_grant.push_back(2); want[2]++;
      step();
      chk("t1_arb_cycle_valid", sm_in_valid, 0);
      chk("t1_arb_cycle_ready", req_ready, 0);
      step();
      chk("t1_first_valid", sm_in_valid, 1);
      chk("t1_grant_id", grant_id, 2);
      chk("t1_req_ready", req_ready, 4'b0100);
      chk("t1_busy", busy, 1);
      wait_idle("t1_done", 200);
      chk("t1_rsp2_beats", rsp_per[2], 10);

      // fairness, from a fresh reset
      rst = 1'b0; step(); step(); rst = 1'b1; step();
      for (int k = 0; k < 8; k++) exp_grant.push_back(k % 4);
      for (int r = 0; r < 4; r++) want[r] += 2;
      n = 0;
      while (!sm_in_valid && n < 20) begin step(); n++; end
      chk("t2_start", 32'(n < 20), 1);
      step(); gap_chk = 1;
      wait_idle("t2_done", 400);
      gap_chk = 0;
      chk("t2_vectors", vec_out_cnt, 9);

      // tag back-pressure
      out_hold = 1; base = vec_start_cnt;
      exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
      exp_grant.push_back(3); exp_grant.push_back(0);
      want[0] += 2; want[1]++; want[2]++; want[3]++;
      n = 0;
      while (vec_start_cnt < base + 4 && n < 100) begin step(); n++; end
      chk("t3_four_grants", 32'(n < 100), 1);
      repeat (15) step();
      chk("t3_stalled_grants", vec_start_cnt - base, 4);
      chk("t3_req_ready", req_ready, 0);
      chk("t3_sm_in_valid", sm_in_valid, 0);
      chk("t3_busy", busy, 1);
      out_hold = 0; base = vec_out_cnt; n = 0;
      while (vec_out_cnt == base && n < 100) begin step(); n++; end
      pop_c = last_pop_cyc;
      n = 0;
      while (vec_start_cnt < base + 5 && n < 20) begin step(); n++; end
      chk("t3_fifth_grant", 32'(n < 20), 1);
      chk("t3_pop_to_beat", first_in_cyc - pop_c, 2);
      wait_idle("t3_done", 300);

      // response back-pressure
      exp_grant.push_back(1); want[1]++; base = rsp_per[1]; n = 0;
      while (rsp_per[1] < base + 4 && n < 100) begin step(); n++; end
      chk("t4_reach4", 32'(n < 100), 1);
      rsp_ready[1] = 1'b0;
      #1;
      chk("t4_sm_out_ready", sm_out_ready, 0);
      chk("t4_rsp_valid", rsp_valid, 4'b0010);
      repeat (4) step();
      chk("t4_sm_out_ready_held", sm_out_ready, 0);
      step();
      chk("t4_cnt_held", rsp_per[1] - base, 4);
      rsp_ready[1] = 1'b1; n = 0;
      while (rsp_per[1] < base + 9 && n < 50) begin step(); n++; end
      chk("t4_busy_before_last", busy, 1);
      wait_idle("t4_done", 100);
      chk("t4_beats", rsp_per[1] - base, 10);

      // protocol error
      force_ov = 1; step();
      chk("t5_sm_out_ready", sm_out_ready, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_perr_not_yet", protocol_err, 0);
      step();
      chk("t5_perr_set", protocol_err, 1);
      force_ov = 0; repeat (3) step();
      chk("t5_perr_sticky", protocol_err, 1);

      // reset mid-vector
      exp_grant.push_back(3); want[3]++; base = acc[3]; n = 0;
      while (acc[3] < base + 4 && n < 50) begin step(); n++; end
      chk("t6_four_beats", acc[3] - base, 4);
      rst = 1'b0;
      #1;
      chk("t6_req_ready", req_ready, 0);
      chk("t6_sm_in_valid", sm_in_valid, 0);
      chk("t6_sm_out_ready", sm_out_ready, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      step();
      chk("t6_busy", busy, 0);
      chk("t6_grant_id", grant_id, 0);
      chk("t6_perr_cleared", protocol_err, 0);
      step();
      rst = 1'b1;
      #1;
      chk("t6_post_req_ready", req_ready, 0);
      chk("t6_post_sm_in_valid", sm_in_valid, 0);
      exp_grant.push_back(0); exp_grant.push_back(2); exp_grant.push_back(3);
      want[0]++; want[2]++; want[3]++;
      wait_idle("t6_done", 300);

      chk("grant_q_left", exp_grant.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/softmax_stream_arbiter.md
Name: softmax_stream_arbiter

Overview:
- Shares one fixed_softmax datapath instance among NUM_REQ independent requester streams.
- Arbitration is round-robin at vector granularity. A grant is held for exactly IN_DEPTH input beats, so vectors are never interleaved.
- A tag FIFO records the grant order, and output beats are steered back to the owning requester in that same order.
- Sits between the requester streams and the softmax datapath's data_in_0 / data_out_0 handshakes.

Parameters:
- NUM_REQ, 4, number of requester streams; must be 2 or more.
- DATA_WIDTH, 8, bits per element, on both input and output.
- IN_NUM, 1, elements per input beat; equals the datapath's DIM_0 × DIM_1 input parallelism.
- OUT_NUM, 1, elements per output beat.
- IN_DEPTH, 10, input beats per vector.
- OUT_DEPTH, 10, output beats per vector.
- TAG_DEPTH, 4, maximum number of vectors in flight; the capacity of the tag FIFO.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req_data  in  NUM_REQ*IN_NUM*DATA_WIDTH  requester r occupies slice r*IN_NUM*DATA_WIDTH +: IN_NUM*DATA_WIDTH.
- req_valid  in  NUM_REQ  per-requester input valid.
- req_ready  out  NUM_REQ  per-requester input ready.
- sm_in_data  out  IN_NUM*DATA_WIDTH  beat to the datapath.
- sm_in_valid  out  1  valid to the datapath.
- sm_in_ready  in  1  datapath input ready.
- sm_out_data  in  OUT_NUM*DATA_WIDTH  datapath result beat.
- sm_out_valid  in  1  datapath output valid.
- sm_out_ready  out  1  ready to the datapath.
- rsp_data  out  OUT_NUM*DATA_WIDTH  equals sm_out_data, broadcast to all requesters.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response ready.
- grant_id  out  $clog2(NUM_REQ)  current or most recent input owner.
- busy  out  1  high in STREAM or when the tag FIFO is non-empty.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - Input FSM goes to IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - grant_id = 0; both beat counters = 0; tag FIFO empty; protocol_err = 0.
  - All req_ready, sm_in_valid, rsp_valid and sm_out_ready read 0 while in reset and in the cycle after it.
- Input FSM, IDLE state:
  - req_ready = 0 and sm_in_valid = 0.
  - Arbitration condition: any req_valid is high and the registered tag count < TAG_DEPTH.
  - When the condition holds, select the first valid requester searching from last_grant+1 modulo NUM_REQ.
  - Register the winner as grant_id, push grant_id into the tag FIFO, and go to STREAM.
  - This costs one arbitration cycle and gives one idle bubble between vectors.
- Input FSM, STREAM state (grant g):
  - Combinational path: sm_in_data = slice g; sm_in_valid = req_valid[g]; req_ready[g] = sm_in_ready; every other req_ready = 0.
  - in_cnt increments on each sm_in_valid & sm_in_ready.
  - On the handshake with in_cnt == IN_DEPTH-1: set in_cnt to 0, set last_grant to g, return to IDLE.
  - The grant is never revoked early. A requester dropping valid mid-vector simply stalls the stream.
- Output steering (head tag h, tag FIFO non-empty):
  - rsp_valid[h] = sm_out_valid; sm_out_ready = rsp_ready[h]; all other rsp_valid = 0.
  - out_cnt increments on each handshake.
  - On the handshake with out_cnt == OUT_DEPTH-1: pop the tag FIFO and set out_cnt to 0.
  - The next tag becomes effective in the following cycle, with no zero-latency bypass.
- Output steering, tag FIFO empty:
  - sm_out_ready = 0 and all rsp_valid = 0.
  - If sm_out_valid is high in this condition, set protocol_err = 1; it is cleared only by reset.
- Tag FIFO rules:
  - Push and pop in the same cycle leave the count unchanged.
  - Full status uses the registered count. A pop in the same cycle does not enable a grant; the grant is taken the next cycle.
  - Read and write pointers wrap modulo TAG_DEPTH.
- Latency: the first sm_in_valid is asserted 1 cycle after the winning req_valid is seen in IDLE. Beats pass through combinationally from then on.
- Reset mid-vector: the partial vector is abandoned. The datapath must be reset in the same cycle (its integration drives its own rst from the same source).

Test Plan:
- Single requester: req 2 sends one vector of 10 beats, values 0..9. Expect a grant 1 cycle later, 10 beats out on sm_in, tag 2 pushed; the 10 output beats appear only on rsp_valid[2]; busy falls after the last response beat.
- Fairness: all four requesters hold req_valid for 8 vectors. Expect grant order 0,1,2,3,0,1,2,3, one idle cycle between vectors, and no interleaving on sm_in.
- Tag back-pressure, TAG_DEPTH = 4: hold sm_out_valid = 0 while 5 vectors are requested. Expect 4 grants, then IDLE with all req_ready = 0. After the first output vector completes, the 5th grant is taken the cycle after the pop.
- Response back-pressure: rsp_ready[1] = 0 for 5 cycles mid-vector. Expect sm_out_ready = 0 for those cycles, out_cnt held, no beat lost, and the pop only after the 10th handshake.
- Protocol error: drive sm_out_valid = 1 with the tag FIFO empty. Expect sm_out_ready = 0 and protocol_err = 1, staying set until rst = 0.
- Reset mid-operation: assert rst = 0 after 4 of 10 beats of requester 3. Expect all outputs 0, FIFO empty, and requester 0 winning the first arbitration afterwards.
